led_tick_gen: RTL and testbench
===============================

# led_tick_gen

Upstream rate source for the board's LED shifter stages. Divides CLOCK_50 into a single-cycle enable pulse `tick` that downstream LED pattern logic uses in place of a divided clock bit. The step rate is selectable from 1 Hz to 128 Hz in powers of two via debounced push-buttons. An optional pause key freezes the pulse stream.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency; base period at rate 0; must be ≥ 256.
- DEBOUNCE_CYC, 1_000_000, number of consecutive stable cycles (20 ms) required to accept a key level; must be ≥ 2.

Ports:
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- KEY  in  3  raw board keys, active-low (pressed = 0):
  - KEY[0] = slower.
  - KEY[1] = faster.
  - KEY[2] = pause toggle.
- tick  out  1  one-cycle enable pulse at the selected rate.
- rate  out  3  current rate index r; step frequency = 2^r Hz.
- paused  out  1  high while pulse generation is frozen.

## Operation
- Reset (RST_N=0 at an edge) drives:
  - Outputs: tick=0, rate=0, paused=0.
  - Divider count=0.
  - Synchronizers=1; debounced key states=1 (released); debounce counters=0.
- Key path, identical per key:
  - Two-flop synchronizer.
  - Debounce counter increments each cycle the synchronized level differs from the debounced state, and clears when they match.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, the debounced state flips and the counter clears.
  - A debounced 1→0 transition produces a registered one-cycle press pulse. Release produces no pulse.
- Rate control:
  - Faster press: rate+1, saturating at 7.
  - Slower press: rate-1, saturating at 0.
  - Faster and slower pulses in the same cycle: no change.
  - Any actual rate change clears the divider count. No tick is issued in that cycle.
  - A saturated press (no change) leaves the divider untouched.
- Divider:
  - period = CLK_HZ >> rate; counter width = clog2(CLK_HZ).
  - When not paused, the count increments each cycle.
  - When count == period-1, it wraps to 0 and tick is registered high for the next cycle.
- Pause:
  - A pause press toggles `paused`.
  - While paused, the count holds and tick=0.
  - Unpausing resumes from the held count; the phase is preserved.
  - Rate presses are still accepted while paused and clear the held count.

## Timing
- Rate 0: first tick is high during cycle CLK_HZ+1 after reset release (edge 1 = first edge with RST_N=1). Ticks then repeat every CLK_HZ cycles, each exactly one cycle wide.
- Key latency: a key held low from edge k changes rate or paused at edge k+DEBOUNCE_CYC+3, visible in the following cycle. Breakdown: 2 synchronizer + DEBOUNCE_CYC debounce + 1 pulse register.
- A key low for fewer than DEBOUNCE_CYC consecutive synchronized cycles has no effect.
- Holding a key pressed produces exactly one press. Auto-repeat is not supported.
- RST_N low mid-operation: all state returns to reset values at that edge, including a tick that is pending or currently high.

## Configuration
- TICK_PAUSE_EN:
  - Defined: KEY[2] pause path as described above.
  - Undefined: KEY[2] is ignored, its synchronizer and debouncer are not built, and `paused` is tied to 0.

## Test plan
Bench parameters: CLK_HZ=256, DEBOUNCE_CYC=4.
- Reset then idle 600 cycles → tick high at cycles 257 and 513 only, each one cycle wide; rate=0, paused=0.
- KEY[1] low 20 cycles starting at edge k → rate=1 from edge k+7. Next tick comes 128 cycles after the divider clear, then every 128 cycles.
- Nine faster presses (each low 10, high 10) → rate saturates at 7 with tick every 2 cycles. Ten slower presses → rate=0.
- KEY[1] low for 3 cycles, then high → rate unchanged, no divider clear, tick cadence unaffected.
- With TICK_PAUSE_EN defined: KEY[2] press when count=100 → paused=1, no ticks for 500 cycles. Second press → tick 156 cycles after resume.
- RST_N low for 1 cycle at rate=5 while paused → rate=0, paused=0. First tick comes 256 cycles after release.

Source files
------------

// File: rtl/led_tick_gen.sv
// led_tick_gen: divides CLOCK_50 into a single-cycle `tick` enable pulse
// whose rate is stepped between 1 Hz and 128 Hz (powers of two) by
// debounced push-buttons. KEY[0] = slower, KEY[1] = faster, KEY[2] = pause.
// Optional feature macro: TICK_PAUSE_EN builds the KEY[2] pause path;
// without it KEY[2] is ignored and `paused` is tied low.
module led_tick_gen #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic [2:0] KEY,
   output logic       tick,
   output logic [2:0] rate,
   output logic       paused
);

   localparam int CW = $clog2(CLK_HZ);
   localparam int DW = $clog2(DEBOUNCE_CYC);

`ifdef TICK_PAUSE_EN
   localparam int NKEYS = 3;
`else
   localparam int NKEYS = 2;
   logic unused_key;
   assign unused_key = KEY[2];
`endif

   logic [NKEYS-1:0] key_press;
   logic [CW-1:0]    count;
   logic [CW-1:0]    period_m1;
   logic             rate_up;
   logic             rate_dn;

   // One identical key path per button: 2-flop sync, debounce, press pulse
   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      logic          sync1;
      logic          sync2;
      logic          db_state;
      logic          db_prev;
      logic          press_q;
      logic [DW-1:0] db_cnt;

      // Press pulse is registered one cycle after the debounced level falls
      always_ff @(posedge CLOCK_50) begin
         if (!RST_N) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            db_state <= 1'b1;
            db_prev  <= 1'b1;
            db_cnt   <= '0;
            press_q  <= 1'b0;
         end else begin
            sync1   <= KEY[i];
            sync2   <= sync1;
            db_prev <= db_state;
            press_q <= db_prev & ~db_state;
            if (sync2 != db_state) begin
               if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                  db_state <= sync2;
                  db_cnt   <= '0;
               end else begin
                  db_cnt <= db_cnt + DW'(1);
               end
            end else begin
               db_cnt <= '0;
            end
         end
      end

      assign key_press[i] = press_q;
   end

   // Simultaneous faster and slower presses cancel; saturated presses do nothing
   assign rate_up   = key_press[1] & ~key_press[0] & (rate != 3'd7);
   assign rate_dn   = key_press[0] & ~key_press[1] & (rate != 3'd0);
   assign period_m1 = CW'((CLK_HZ >> rate) - 1);

`ifdef TICK_PAUSE_EN
   logic pause_q;

   // Each debounced pause press flips the frozen state
   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         pause_q <= 1'b0;
      end else if (key_press[2]) begin
         pause_q <= ~pause_q;
      end
   end

   assign paused = pause_q;
`else
   assign paused = 1'b0;
`endif

   // Rate register and divider; a real rate change restarts the phase and suppresses the tick
   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         rate  <= 3'd0;
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (rate_up) begin
            rate  <= rate + 3'd1;
            count <= '0;
         end else if (rate_dn) begin
            rate  <= rate - 3'd1;
            count <= '0;
         end else if (!paused) begin
            if (count == period_m1) begin
               count <= '0;
               tick  <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_led_tick_gen.sv
// tb_led_tick_gen: directed, self-checking bench for led_tick_gen with
// CLK_HZ=256 and DEBOUNCE_CYC=4. Follows TICK_PAUSE_EN the same way the RTL does.
module tb_led_tick_gen;

   logic       CLOCK_50;
   logic       RST_N;
   logic [2:0] KEY;
   logic       tick;
   logic [2:0] rate;
   logic       paused;

   int pass_cnt;
   int total_cnt;
   int edge_cnt;
   int tick_q[$];

   typedef struct {
      logic [2:0] mask;
      int         low_cyc;
      int         high_cyc;
      logic [2:0] exp_rate;
      logic       exp_paused;
   } vec_t;

   vec_t vecs[$];

   led_tick_gen #(
      .CLK_HZ      (256),
      .DEBOUNCE_CYC(4)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RST_N   (RST_N),
      .KEY     (KEY),
      .tick    (tick),
      .rate    (rate),
      .paused  (paused)
   );

   // Free-running 10 ns clock
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // Number of edges since reset was released; edge 1 is the first with RST_N high
   always @(posedge CLOCK_50) begin
      if (!RST_N) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   // Log the edge number after which tick was high, sampled mid-cycle
   always @(negedge CLOCK_50) begin
      if (RST_N && tick === 1'b1) tick_q.push_back(edge_cnt);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic runTo(input int e);
      while (edge_cnt < e) step(1);
   endtask

   task automatic doReset();
      RST_N = 1'b0;
      step(1);
      RST_N = 1'b1;
      tick_q.delete();
   endtask

   // Hold the keys in mask low for lowc edges, then release for highc edges
   task automatic applyStimulus(input logic [2:0] mask, input int lowc, input int highc);
      KEY = ~mask;
      step(lowc);
      KEY = 3'b111;
      step(highc);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      else
         pass_cnt++;
   endtask

   task automatic checkTicks(input string name, input int n, input int e0, input int e1, input int e2);
      int exp_e[3];
      exp_e = '{e0, e1, e2};
      checkOutput({name, "_count"}, tick_q.size(), n);
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_edge%0d", name, i),
                     (i < tick_q.size()) ? tick_q[i] : -1, exp_e[i]);
   endtask

   // Main sequence: reset, idle cadence, rate steps, table of presses, pause, mid-run reset
   initial begin
      int bad;
      logic pe;
`ifdef TICK_PAUSE_EN
      pe = 1'b1;
`else
      pe = 1'b0;
`endif
      pass_cnt  = 0;
      total_cnt = 0;
      RST_N     = 1'b0;
      KEY       = 3'b111;

      // Reset state
      step(2);
      checkOutput("rst_tick", tick, 0);
      checkOutput("rst_rate", rate, 0);
      checkOutput("rst_paused", paused, 0);

      // Idle at rate 0: ticks after edges 256 and 512 only
      doReset();
      runTo(600);
      checkTicks("A_idle", 2, 256, 512, 0);
      checkOutput("A_rate", rate, 0);
      checkOutput("A_paused", paused, 0);

      // Faster key low from edge 10 for 20 edges: rate 1 at edge 17, ticks every 128 after
      doReset();
      runTo(9);
      KEY = 3'b101;
      runTo(16);
      checkOutput("B_rate_before", rate, 0);
      step(1);
      checkOutput("B_rate_after", rate, 1);
      runTo(29);
      KEY = 3'b111;
      runTo(420);
      checkTicks("B_ticks", 3, 145, 273, 401);

      // Glitch on faster and a saturated slower press leave the cadence alone
      doReset();
      runTo(99);
      KEY = 3'b101;
      runTo(102);
      KEY = 3'b111;
      runTo(199);
      KEY = 3'b110;
      runTo(209);
      KEY = 3'b111;
      runTo(600);
      checkTicks("D_cadence", 2, 256, 512, 0);
      checkOutput("D_rate", rate, 0);

      // Nine faster presses saturate at rate 7, tick every 2 edges
      doReset();
      for (int i = 0; i < 9; i++) applyStimulus(3'b010, 10, 10);
      checkOutput("C_rate_sat", rate, 7);
      tick_q.delete();
      step(20);
      checkOutput("C_tick_count", tick_q.size(), 10);
      bad = 0;
      for (int i = 1; i < tick_q.size(); i++)
         if (tick_q[i] - tick_q[i-1] != 2) bad++;
      checkOutput("C_cadence_bad", bad, 0);

      // Table of presses starting from rate 7
      vecs.push_back('{3'b010, 10, 10, 3'd7, 1'b0});
      for (int i = 0; i < 10; i++)
         vecs.push_back('{3'b001, 10, 10, 3'((i < 7) ? 6 - i : 0), 1'b0});
      vecs.push_back('{3'b010, 3, 10, 3'd0, 1'b0});
      vecs.push_back('{3'b010, 4, 10, 3'd1, 1'b0});
      vecs.push_back('{3'b001, 3, 10, 3'd1, 1'b0});
      vecs.push_back('{3'b011, 10, 10, 3'd1, 1'b0});
      vecs.push_back('{3'b001, 4, 10, 3'd0, 1'b0});
      vecs.push_back('{3'b100, 10, 10, 3'd0, pe});
      vecs.push_back('{3'b010, 10, 10, 3'd1, pe});
      vecs.push_back('{3'b100, 10, 10, 3'd1, 1'b0});
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].mask, vecs[i].low_cyc, vecs[i].high_cyc);
         checkOutput($sformatf("vec%0d_rate", i), rate, vecs[i].exp_rate);
         checkOutput($sformatf("vec%0d_paused", i), paused, vecs[i].exp_paused);
      end

      // Pause at held count 100, resume at edge 607, next tick 156 edges later
      doReset();
      runTo(92);
      KEY = 3'b011;
`ifdef TICK_PAUSE_EN
      runTo(99);
      checkOutput("E_paused_before", paused, 0);
      step(1);
      checkOutput("E_paused_after", paused, 1);
      runTo(102);
      KEY = 3'b111;
      runTo(599);
      KEY = 3'b011;
      runTo(606);
      checkOutput("E_no_ticks", tick_q.size(), 0);
      checkOutput("E_still_paused", paused, 1);
      step(1);
      checkOutput("E_resumed", paused, 0);
      runTo(609);
      KEY = 3'b111;
      runTo(800);
      checkTicks("E_resume_tick", 1, 763, 0, 0);
`else
      runTo(102);
      KEY = 3'b111;
      runTo(600);
      checkOutput("E_paused_tied", paused, 0);
      checkTicks("E_ignored", 2, 256, 512, 0);
`endif

      // Reset mid-operation at rate 5
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(3'b010, 10, 10);
      checkOutput("F_rate5", rate, 5);
`ifdef TICK_PAUSE_EN
      applyStimulus(3'b100, 10, 10);
      checkOutput("F_paused", paused, 1);
`else
      for (int i = 0; i < 20 && tick !== 1'b1; i++) step(1);
      checkOutput("F_tick_seen", tick, 1);
`endif
      RST_N = 1'b0;
      step(1);
      checkOutput("F_rst_rate", rate, 0);
      checkOutput("F_rst_paused", paused, 0);
      checkOutput("F_rst_tick", tick, 0);
      RST_N = 1'b1;
      tick_q.delete();
      runTo(300);
      checkTicks("F_after_rst", 1, 256, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
